id_rf_read_seq: RTL and testbench
=================================

# id_rf_read_seq

Read-port sequencer between the instruction decoder and a single-port, synchronous-read register file. It accepts one decode-stage read request (up to two source registers) via valid/ready and issues the reads serially on the one physical port. It returns both operands together to the execute stage via valid/ready, and forwards a same-cycle writeback so that no stale values reach execute.

## Interface
- `RADDR_WIDTH`, default 5: register address width.
- `RDATA_WIDTH`, default 32: register data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  decoder has a request.
- `req_ready_o`  out  1  sequencer can accept a request.
- `reg1_re_i`, `reg2_re_i`  in  1 each  source 1 / source 2 required.
- `reg1_raddr_i`, `reg2_raddr_i`  in  RADDR_WIDTH each  source addresses.
- `rf_re_o`  out  1  register-file read strobe.
- `rf_raddr_o`  out  RADDR_WIDTH  register-file read address.
- `rf_rdata_i`  in  RDATA_WIDTH  register-file data, valid the cycle after `rf_re_o`.
- `wb_we_i`  in  1  writeback write enable.
- `wb_waddr_i`  in  RADDR_WIDTH  writeback address.
- `wb_wdata_i`  in  RDATA_WIDTH  writeback data.
- `out_valid_o`  out  1  operands valid.
- `out_ready_i`  in  1  execute accepts operands.
- `reg1_rdata_o`, `reg2_rdata_o`  out  RDATA_WIDTH each  operands.
- `flush_i`  in  1  synchronous pipeline flush.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RD1, RD2, WAIT, VALID.
- `req_ready_o` is high only in IDLE. A request is accepted on `req_valid_i & req_ready_o & ~flush_i`.
- On accept:
  - latch both addresses;
  - set need1 = `reg1_re_i & (reg1_raddr_i != 0)` and need2 likewise for source 2;
  - clear each operand register whose need bit is 0 (x0 and unused sources read as 0 and are never issued).
- Next state after accept: RD1 if need1, else RD2 if need2, else VALID.
- RD1:
  - `rf_re_o`=1, `rf_raddr_o`=addr1, cap_sel<=1;
  - next state RD2 if need2, else WAIT.
- RD2:
  - `rf_re_o`=1, `rf_raddr_o`=addr2, cap_sel<=2;
  - if cap_sel==1, reg1 <= `rf_rdata_i` (or the bypass value, see below);
  - next state WAIT.
- WAIT: capture `rf_rdata_i` into the operand selected by cap_sel, cap_sel<=0, next state VALID.
- VALID: `out_valid_o`=1 and operands stay stable. On `out_ready_i`, return to IDLE.
- Outside RD1/RD2: `rf_re_o`=0 and `rf_raddr_o`=0.
- Writeback bypass:
  - Condition: in an issue cycle (RD1/RD2), `wb_we_i` is high and `wb_waddr_i` equals the issued address (nonzero by construction).
  - Action: set a registered bypass flag and store `wb_wdata_i`.
  - On the capture cycle, the stored value replaces `rf_rdata_i`.
  - Writes in other cycles are the register file's responsibility and are not bypassed.
- Flush:
  - Applies in any state; next state IDLE, cap_sel and bypass flag cleared, operands unchanged.
  - Flush has priority over accept and over `out_ready_i` in the same cycle.
- Reset: state IDLE, cap_sel 0, bypass flag 0, operand registers 0, need bits 0.
  - Resulting outputs: `req_ready_o`=1, `out_valid_o`=0, `rf_re_o`=0, `rf_raddr_o`=0, `busy_o`=0.
  - Reset asserted mid-sequence abandons the request; no output pulse occurs after deassertion.

## Timing
- Accept at edge T; `out_valid_o` rises after:
  - T+4 with both sources needed;
  - T+3 with one source needed;
  - T+1 with none needed.
- Read data is sampled exactly one cycle after its `rf_re_o` cycle.
- Read issue is back-to-back: RD2 follows RD1 directly.
- Throughput: one request per (latency + 1) cycles minimum, because IDLE is always visited between requests.
- `out_valid_o` stays high until `out_ready_i` or `flush_i`. Operands do not change while `out_valid_o` is high.
- All outputs are registered-state decodes. There is no combinational path from `req_valid_i` to `rf_re_o`.

## Test plan
- Reset, then request re1=re2=1, addr1=3, addr2=7; RF holds x3=0x11, x7=0x22.
  - Expect `rf_raddr_o` 3 then 7 on consecutive cycles.
  - Expect `out_valid_o` at T+4 with reg1=0x11, reg2=0x22.
- I-type style request (re1=1, addr1=5, re2=0), x5=0xDEADBEEF.
  - Expect a single read, `out_valid_o` at T+3, reg1=0xDEADBEEF, reg2=0.
- re1=1 with addr1=0 and re2=0.
  - Expect no `rf_re_o` pulse, `out_valid_o` at T+1, both operands 0.
- Bypass: during the RD1 issue of addr1=9, drive `wb_we_i`=1, `wb_waddr_i`=9, `wb_wdata_i`=0xCAFE while the RF still returns the old value 0x1.
  - Expect reg1=0xCAFE.
- Backpressure: hold `out_ready_i`=0 for 5 cycles in VALID.
  - Expect `out_valid_o` and the operands stable, `req_ready_o`=0.
  - Raise `out_ready_i` → IDLE next cycle.
- Flush in RD2 → IDLE next cycle, no `out_valid_o`. Repeat with `rst_n` low in WAIT → all outputs at reset values immediately.

Source files
------------

// File: rtl/id_rf_read_seq.sv
// Read-port sequencer: serialises up to two source-register reads onto one
// synchronous-read register-file port and returns both operands together.
module id_rf_read_seq #(
    parameter int RADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   reg1_re_i,
    input  logic                   reg2_re_i,
    input  logic [RADDR_WIDTH-1:0] reg1_raddr_i,
    input  logic [RADDR_WIDTH-1:0] reg2_raddr_i,
    output logic                   rf_re_o,
    output logic [RADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [RDATA_WIDTH-1:0] rf_rdata_i,
    input  logic                   wb_we_i,
    input  logic [RADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [RDATA_WIDTH-1:0] wb_wdata_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [RDATA_WIDTH-1:0] reg1_rdata_o,
    output logic [RDATA_WIDTH-1:0] reg2_rdata_o,
    input  logic                   flush_i,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD1   = 3'd1,
        ST_RD2   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_VALID = 3'd4
    } state_t;

    localparam logic [RADDR_WIDTH-1:0] ADDR_ZERO = {RADDR_WIDTH{1'b0}};
    localparam logic [RDATA_WIDTH-1:0] DATA_ZERO = {RDATA_WIDTH{1'b0}};

    state_t                   state_r;
    state_t                   nxt_state_s;
    logic                     accept_s;
    logic                     need1_s;
    logic                     need2_s;
    logic [RADDR_WIDTH-1:0]   addr1_nxt_s;
    logic [RADDR_WIDTH-1:0]   addr2_nxt_s;
    logic [RADDR_WIDTH-1:0]   nxt_raddr_s;
    logic                     byp_hit_s;
    logic [RDATA_WIDTH-1:0]   cap_data_s;

    logic [RADDR_WIDTH-1:0]   addr1_r;
    logic [RADDR_WIDTH-1:0]   addr2_r;
    logic                     need1_r;
    logic                     need2_r;
    logic [1:0]               cap_sel_r;
    logic                     byp_r;
    logic [RDATA_WIDTH-1:0]   byp_data_r;
    logic [RDATA_WIDTH-1:0]   reg1_r;
    logic [RDATA_WIDTH-1:0]   reg2_r;

    logic                     req_ready_r;
    logic                     busy_r;
    logic                     out_valid_r;
    logic                     rf_re_r;
    logic [RADDR_WIDTH-1:0]   rf_raddr_r;

    assign accept_s    = req_valid_i & (state_r == ST_IDLE) & ~flush_i;
    assign need1_s     = reg1_re_i & (reg1_raddr_i != ADDR_ZERO);
    assign need2_s     = reg2_re_i & (reg2_raddr_i != ADDR_ZERO);
    assign addr1_nxt_s = accept_s ? reg1_raddr_i : addr1_r;
    assign addr2_nxt_s = accept_s ? reg2_raddr_i : addr2_r;

    // rf_raddr_r always holds the address being issued in RD1/RD2
    assign byp_hit_s  = ((state_r == ST_RD1) | (state_r == ST_RD2)) & wb_we_i &
                        (wb_waddr_i == rf_raddr_r);
    assign cap_data_s = byp_r ? byp_data_r : rf_rdata_i;

    assign req_ready_o  = req_ready_r;
    assign busy_o       = busy_r;
    assign out_valid_o  = out_valid_r;
    assign rf_re_o      = rf_re_r;
    assign rf_raddr_o   = rf_raddr_r;
    assign reg1_rdata_o = reg1_r;
    assign reg2_rdata_o = reg2_r;

    // Next-state selection; flush overrides every transition
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (need1_s) begin
                        nxt_state_s = ST_RD1;
                    end else if (need2_s) begin
                        nxt_state_s = ST_RD2;
                    end else begin
                        nxt_state_s = ST_VALID;
                    end
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_RD1: begin
                if (need2_r) begin
                    nxt_state_s = ST_RD2;
                end else begin
                    nxt_state_s = ST_WAIT;
                end
            end
            ST_RD2:  nxt_state_s = ST_WAIT;
            ST_WAIT: nxt_state_s = ST_VALID;
            ST_VALID: begin
                if (out_ready_i) begin
                    nxt_state_s = ST_IDLE;
                end else begin
                    nxt_state_s = ST_VALID;
                end
            end
            default: nxt_state_s = ST_IDLE;
        endcase
        if (flush_i) begin
            nxt_state_s = ST_IDLE;
        end else begin
            nxt_state_s = nxt_state_s;
        end
    end

    // Read address that will be on the port in the next state
    always_comb begin
        nxt_raddr_s = ADDR_ZERO;
        case (nxt_state_s)
            ST_RD1:  nxt_raddr_s = addr1_nxt_s;
            ST_RD2:  nxt_raddr_s = addr2_nxt_s;
            default: nxt_raddr_s = ADDR_ZERO;
        endcase
    end

    // State register with outputs registered from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            rf_re_r     <= 1'b0;
            rf_raddr_r  <= ADDR_ZERO;
        end else begin
            state_r     <= nxt_state_s;
            req_ready_r <= (nxt_state_s == ST_IDLE);
            busy_r      <= (nxt_state_s != ST_IDLE);
            out_valid_r <= (nxt_state_s == ST_VALID);
            rf_re_r     <= (nxt_state_s == ST_RD1) | (nxt_state_s == ST_RD2);
            rf_raddr_r  <= nxt_raddr_s;
        end
    end

    // Request latch, capture steering, bypass tracking and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr1_r    <= ADDR_ZERO;
            addr2_r    <= ADDR_ZERO;
            need1_r    <= 1'b0;
            need2_r    <= 1'b0;
            cap_sel_r  <= 2'd0;
            byp_r      <= 1'b0;
            byp_data_r <= DATA_ZERO;
            reg1_r     <= DATA_ZERO;
            reg2_r     <= DATA_ZERO;
        end else if (flush_i) begin
            cap_sel_r <= 2'd0;
            byp_r     <= 1'b0;
        end else if (accept_s) begin
            addr1_r   <= reg1_raddr_i;
            addr2_r   <= reg2_raddr_i;
            need1_r   <= need1_s;
            need2_r   <= need2_s;
            cap_sel_r <= 2'd0;
            byp_r     <= 1'b0;
            if (!need1_s) begin
                reg1_r <= DATA_ZERO;
            end else begin
                reg1_r <= reg1_r;
            end
            if (!need2_s) begin
                reg2_r <= DATA_ZERO;
            end else begin
                reg2_r <= reg2_r;
            end
        end else begin
            case (state_r)
                ST_RD1: begin
                    cap_sel_r <= 2'd1;
                    byp_r     <= byp_hit_s;
                    if (byp_hit_s) begin
                        byp_data_r <= wb_wdata_i;
                    end else begin
                        byp_data_r <= byp_data_r;
                    end
                end
                ST_RD2: begin
                    // RD2 is also the capture cycle for a preceding RD1
                    cap_sel_r <= 2'd2;
                    if (cap_sel_r == 2'd1) begin
                        reg1_r <= cap_data_s;
                    end else begin
                        reg1_r <= reg1_r;
                    end
                    byp_r <= byp_hit_s;
                    if (byp_hit_s) begin
                        byp_data_r <= wb_wdata_i;
                    end else begin
                        byp_data_r <= byp_data_r;
                    end
                end
                ST_WAIT: begin
                    if ((cap_sel_r == 2'd1) && need1_r) begin
                        reg1_r <= cap_data_s;
                    end else if (cap_sel_r == 2'd2) begin
                        reg2_r <= cap_data_s;
                    end else begin
                        reg1_r <= reg1_r;
                    end
                    cap_sel_r <= 2'd0;
                    byp_r     <= 1'b0;
                end
                default: begin
                    cap_sel_r <= cap_sel_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_rf_read_seq.sv
// Scoreboard bench for id_rf_read_seq with a synchronous-read register-file model.
module tb_id_rf_read_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        reg1_re_i;
    logic        reg2_re_i;
    logic [4:0]  reg1_raddr_i;
    logic [4:0]  reg2_raddr_i;
    logic        rf_re_o;
    logic [4:0]  rf_raddr_o;
    logic [31:0] rf_rdata_i;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] reg1_rdata_o;
    logic [31:0] reg2_rdata_o;
    logic        flush_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];
    logic [31:0] rf_mem [32];

    id_rf_read_seq #(.RADDR_WIDTH(5), .RDATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .reg1_re_i(reg1_re_i), .reg2_re_i(reg2_re_i),
        .reg1_raddr_i(reg1_raddr_i), .reg2_raddr_i(reg2_raddr_i),
        .rf_re_o(rf_re_o), .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .reg1_rdata_o(reg1_rdata_o), .reg2_rdata_o(reg2_rdata_o),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file never honours writes here, so a bypass must come from the DUT
    always @(posedge clk) begin
        if (rf_re_o) rf_rdata_i <= rf_mem[rf_raddr_o];
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({req_ready_o, out_valid_o, rf_re_o, rf_raddr_o, busy_o} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s: ready/valid/re/raddr/busy got %b %b %b %0d %b want 1 0 0 0 0",
                     name, req_ready_o, out_valid_o, rf_re_o, rf_raddr_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_outputs");
        checks++;
        if ({reg1_rdata_o, reg2_rdata_o} !== 64'd0) begin
            errors++;
            $display("FAIL reset_operands: got %h %h want 0 0", reg1_rdata_o, reg2_rdata_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one request, monitors reads/latency, checks scoreboard, then handshakes.
    task automatic run_req(input string name, input logic re1, input logic [4:0] a1,
                           input logic re2, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input int exp_lat, input int exp_nrd,
                           input logic [4:0] ea0, input logic [4:0] ea1,
                           input logic do_wb, input logic [4:0] wa, input logic [31:0] wd,
                           input int hold);
        int lat;
        int nrd;
        logic [4:0] rd_addr [4];
        logic [63:0] exp;
        lat = 0;
        nrd = 0;
        req_valid_i = 1'b1; reg1_re_i = re1; reg1_raddr_i = a1;
        reg2_re_i = re2; reg2_raddr_i = a2;
        sb_q.push_back({e1, e2});
        @(posedge clk);
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid_i = 1'b0;
                wb_we_i = do_wb; wb_waddr_i = wa; wb_wdata_i = wd;
            end else begin
                wb_we_i = 1'b0;
            end
            if (rf_re_o && nrd < 4) begin
                rd_addr[nrd] = rf_raddr_o;
                nrd++;
            end
            if (out_valid_o) lat = k;
        end
        wb_we_i = 1'b0;
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (nrd !== exp_nrd) begin
            errors++;
            $display("FAIL %s_read_count: got %0d want %0d", name, nrd, exp_nrd);
        end
        if (exp_nrd > 0 && nrd > 0) begin
            checks++;
            if (rd_addr[0] !== ea0) begin
                errors++;
                $display("FAIL %s_raddr0: got %0d want %0d", name, rd_addr[0], ea0);
            end
        end
        if (exp_nrd > 1 && nrd > 1) begin
            checks++;
            if (rd_addr[1] !== ea1) begin
                errors++;
                $display("FAIL %s_raddr1: got %0d want %0d", name, rd_addr[1], ea1);
            end
        end
        exp = sb_q.pop_front();
        if (lat == 0) return;
        checks++;
        if ({reg1_rdata_o, reg2_rdata_o} !== exp) begin
            errors++;
            $display("FAIL %s_operands: got %h %h want %h %h", name,
                     reg1_rdata_o, reg2_rdata_o, exp[63:32], exp[31:0]);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if ({out_valid_o, req_ready_o, reg1_rdata_o, reg2_rdata_o} !== {1'b1, 1'b0, exp}) begin
                errors++;
                $display("FAIL %s_hold%0d: valid %b ready %b ops %h %h want 1 0 %h %h", name, h,
                         out_valid_o, req_ready_o, reg1_rdata_o, reg2_rdata_o, exp[63:32], exp[31:0]);
            end
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        check_idle_outputs({name, "_release"});
    endtask

    task automatic test_flush_rd2();
        logic [63:0] snap;
        logic seen;
        snap = {reg1_rdata_o, reg2_rdata_o};
        seen = 1'b0;
        req_valid_i = 1'b1; reg1_re_i = 1'b1; reg1_raddr_i = 5'd3;
        reg2_re_i = 1'b1; reg2_raddr_i = 5'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({rf_re_o, rf_raddr_o} !== {1'b1, 5'd7}) begin
            errors++;
            $display("FAIL flush_in_rd2: re/raddr got %b %0d want 1 7", rf_re_o, rf_raddr_o);
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_idle_outputs("flush_idle");
        checks++;
        if ({reg1_rdata_o, reg2_rdata_o} !== snap) begin
            errors++;
            $display("FAIL flush_operands: got %h %h want %h", reg1_rdata_o, reg2_rdata_o, snap);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_valid: valid seen %b want 0", seen);
        end
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        seen = 1'b0;
        req_valid_i = 1'b1; reg1_re_i = 1'b1; reg1_raddr_i = 5'd5;
        reg2_re_i = 1'b0; reg2_raddr_i = 5'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, rf_re_o, out_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL wait_state: busy/re/valid got %b%b%b want 100", busy_o, rf_re_o, out_valid_o);
        end
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset_outputs");
        checks++;
        if ({reg1_rdata_o, reg2_rdata_o} !== 64'd0) begin
            errors++;
            $display("FAIL async_reset_operands: got %h %h want 0 0", reg1_rdata_o, reg2_rdata_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_o || rf_re_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: activity %b want 0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + i;
        rf_mem[3] = 32'h11; rf_mem[7] = 32'h22; rf_mem[5] = 32'hDEADBEEF; rf_mem[9] = 32'h1;
        rst_n = 1'b0; req_valid_i = 1'b0; reg1_re_i = 1'b0; reg2_re_i = 1'b0;
        reg1_raddr_i = 5'd0; reg2_raddr_i = 5'd0; wb_we_i = 1'b0; wb_waddr_i = 5'd0;
        wb_wdata_i = 32'd0; out_ready_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        test_reset();
        run_req("both",  1'b1, 5'd3, 1'b1, 5'd7, 32'h11, 32'h22, 4, 2, 5'd3, 5'd7, 1'b0, 5'd0, 32'd0, 0);
        run_req("itype", 1'b1, 5'd5, 1'b0, 5'd7, 32'hDEADBEEF, 32'd0, 3, 1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 0);
        run_req("x0",    1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1, 0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 0);
        run_req("src2",  1'b0, 5'd3, 1'b1, 5'd7, 32'd0, 32'h22, 3, 1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 0);
        run_req("bypass", 1'b1, 5'd9, 1'b0, 5'd0, 32'hCAFE, 32'd0, 3, 1, 5'd9, 5'd0, 1'b1, 5'd9, 32'hCAFE, 0);
        run_req("wb_other", 1'b1, 5'd9, 1'b0, 5'd0, 32'h1, 32'd0, 3, 1, 5'd9, 5'd0, 1'b1, 5'd4, 32'hBAD, 0);
        run_req("bkpr",  1'b1, 5'd7, 1'b1, 5'd3, 32'h22, 32'h11, 4, 2, 5'd7, 5'd3, 1'b0, 5'd0, 32'd0, 5);
        test_flush_rd2();
        run_req("after_flush", 1'b1, 5'd3, 1'b1, 5'd5, 32'h11, 32'hDEADBEEF, 4, 2, 5'd3, 5'd5, 1'b0, 5'd0, 32'd0, 1);
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
